writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback/retire stage directly upstream of the register file write port.
- Accepts completed results from the ALU and the LSU over valid/ready handshakes and arbitrates between them.
- Produces the register file write interface: a glitch-free en_w rising-edge strobe with address, both data buses and source select held stable around it.
- Keeps a 32-entry busy scoreboard so operand fetch can detect RAW hazards and issue can stall on WAW hazards.

Parameters:
- DataWidth, 32, width of result data and of the register file data buses.
- CntWidth, 32, width of the retired-write counter.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- issue_valid_i  in  1  an instruction with destination issue_rd_i is being issued.
- issue_rd_i  in  5  destination register of the issued instruction.
- issue_ready_o  out  1  issue may be accepted: low when busy[issue_rd_i] is set (WAW stall).
- raddr_a_i  in  5  operand A address from operand fetch.
- raddr_b_i  in  5  operand B address from operand fetch.
- hazard_a_o  out  1  operand A has a pending write.
- hazard_b_o  out  1  operand B has a pending write.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU result accepted this cycle.
- alu_rd_i  in  5  ALU destination register.
- alu_wdata_i  in  DataWidth  ALU result.
- lsu_valid_i  in  1  LSU load data valid.
- lsu_ready_o  out  1  LSU data accepted this cycle.
- lsu_rd_i  in  5  LSU destination register.
- lsu_rdata_i  in  DataWidth  LSU load data.
- rf_en_w_o  out  1  write strobe; the register file writes on its rising edge.
- rf_req_w_o  out  1  write request qualifier.
- rf_waddr_o  out  5  write address.
- rf_wdata_alu_o  out  DataWidth  ALU data bus.
- rf_wdata_lsu_o  out  DataWidth  LSU data bus.
- rf_soursel_o  out  1  0 selects ALU data, 1 selects LSU data.
- retire_cnt_o  out  CntWidth  count of performed register writes.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM goes to IDLE; busy vector is cleared.
  - All rf_* outputs, retire_cnt_o and both ready outputs are driven to 0.
  - Any in-flight write is dropped and rf_en_w_o falls immediately.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: alu_ready_o/lsu_ready_o are asserted per arbitration. On acceptance, capture rd, data and source into holding registers and go to SETUP.
  - SETUP: drive rf_waddr_o, rf_wdata_*_o (the unselected bus is 0), rf_soursel_o and rf_req_w_o=1; rf_en_w_o=0.
  - STROBE: rf_en_w_o=1 for exactly one cycle; all other rf_* outputs unchanged.
  - HOLD: rf_en_w_o=0, rf_* still held; then return to IDLE and drop rf_req_w_o to 0.
- Latency and throughput:
  - Accept at edge N; rf_en_w_o rises in cycle N+2 and is back at 0 in N+3; ready again in N+4.
  - Throughput is one write per 4 cycles.
- Arbitration: fixed LSU priority.
  - lsu_ready_o = IDLE.
  - alu_ready_o = IDLE & ~lsu_valid_i.
  - Ready outputs are low in all other states.
- x0 handling:
  - A result with rd=0 is accepted and the FSM still sequences.
  - rf_req_w_o and rf_en_w_o stay 0 for it; retire_cnt_o does not increment.
- Scoreboard:
  - Issue: issue_valid_i & issue_ready_o & issue_rd_i!=0 sets busy[issue_rd_i].
  - Retire: in the STROBE cycle, busy[rd] is cleared at the closing edge.
  - Same-cycle issue to a register being cleared is blocked by issue_ready_o; no set/clear collision is possible.
  - issue_ready_o is forced 1 for issue_rd_i=0.
- Hazards:
  - hazard_x_o = busy[raddr_x_i] & (raddr_x_i!=0).
  - Combinational; no bypass, so a cleared bit is visible the cycle after STROBE.
- retire_cnt_o:
  - Increments at the end of each STROBE cycle with rd!=0.
  - Wraps from all-ones to 0.
- Inputs are not checked for a result without a matching issue; the write proceeds and clearing an already-clear bit is harmless.

Test Plan:
- Reset then ALU result rd=5, data 0xDEADBEEF → SETUP shows waddr=5, soursel=0, req_w=1; en_w high exactly one cycle, 2 cycles after acceptance; retire_cnt_o=1.
- ALU rd=3 and LSU rd=4 both valid in IDLE → LSU accepted first (soursel=1, data on rf_wdata_lsu_o); ALU accepted 4 cycles later.
- Issue rd=7; query raddr_a=7 → hazard_a_o=1. Issue rd=7 again → issue_ready_o=0. After the ALU writeback STROBE → hazard_a_o=0 and issue_ready_o=1.
- Result with rd=0 → handshake completes, en_w/req_w never rise, retire_cnt_o unchanged, hazard_a_o=0 for raddr_a=0.
- Assert rst_i during the STROBE cycle → rf_en_w_o drops to 0 without waiting for a clock edge; busy vector reads all zero; next result is accepted in IDLE.
- Preload retire_cnt_o to all-ones via repeated writes (reduced CntWidth=4: 15 writes), then one more write → retire_cnt_o wraps to 0.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback/retire stage feeding the register file write port.
// Arbitrates ALU and LSU results (LSU has fixed priority) and sequences each
// accepted result through SETUP -> STROBE -> HOLD so that the register-file
// strobe rises only after address/data/select are stable and falls before
// they change. It also keeps a 32-entry busy scoreboard for RAW/WAW detection.
//
// Handshake: a transfer on a valid/ready pair happens at the rising clk_i
// edge where both valid and ready are high. Ready depends only on state and
// on lsu_valid_i (for the ALU port), never on the port's own valid, and the
// producer must hold valid and its payload stable until that edge.
module writeback_unit #(
    parameter int DataWidth = 32,
    parameter int CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_rd_i,
    output logic                 issue_ready_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [4:0]           alu_rd_i,
    input  logic [DataWidth-1:0] alu_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_rd_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    output logic                 rf_en_w_o,
    output logic                 rf_req_w_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_alu_o,
    output logic [DataWidth-1:0] rf_wdata_lsu_o,
    output logic                 rf_soursel_o,
    output logic [CntWidth-1:0]  retire_cnt_o,
    output logic [1:0]           fsm_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] busy_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        accept_lsu;
    logic        accept_alu;
    logic        accept;
    logic [4:0]  accept_rd;
    logic        issue_fire;
    logic        retire;

    // Fixed-priority arbitration; readies forced low while reset is asserted.
    always_comb begin
        lsu_ready_o = (state_q == IDLE) & ~rst_i;
        alu_ready_o = (state_q == IDLE) & ~rst_i & ~lsu_valid_i;
        accept_lsu  = lsu_valid_i & lsu_ready_o;
        accept_alu  = alu_valid_i & alu_ready_o;
        accept      = accept_lsu | accept_alu;
        accept_rd   = accept_lsu ? lsu_rd_i : alu_rd_i;
    end

    // Next-state logic: fixed four-cycle sequence once a result is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign fsm_state_o = state_q;

    // Register-file outputs come straight from flops so en_w cannot glitch.
    // rf_req_w_o doubles as "this write targets a real register" (rd != 0).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_en_w_o      <= 1'b0;
            rf_req_w_o     <= 1'b0;
            rf_waddr_o     <= 5'd0;
            rf_wdata_alu_o <= '0;
            rf_wdata_lsu_o <= '0;
            rf_soursel_o   <= 1'b0;
        end else begin
            if (accept) begin
                rf_waddr_o     <= accept_rd;
                rf_soursel_o   <= accept_lsu;
                rf_wdata_alu_o <= accept_lsu ? '0 : alu_wdata_i;
                rf_wdata_lsu_o <= accept_lsu ? lsu_rdata_i : '0;
                rf_req_w_o     <= (accept_rd != 5'd0);
            end else if (state_q == HOLD) begin
                rf_req_w_o <= 1'b0;
            end
            rf_en_w_o <= (state_q == SETUP) & rf_req_w_o;
        end
    end

    // Scoreboard set/clear masks; issue to a busy rd stalls, so they never overlap.
    always_comb begin
        issue_ready_o = (issue_rd_i == 5'd0) | ~busy_q[issue_rd_i];
        issue_fire    = issue_valid_i & issue_ready_o & (issue_rd_i != 5'd0);
        retire        = (state_q == STROBE) & rf_req_w_o;
        set_mask      = {31'd0, issue_fire} << issue_rd_i;
        clr_mask      = {31'd0, retire} << rf_waddr_o;
    end

    // Busy vector and retired-write counter (counter wraps naturally).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q       <= 32'd0;
            retire_cnt_o <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
            if (retire) begin
                retire_cnt_o <= retire_cnt_o + CntWidth'(1);
            end
        end
    end

    // Hazards are straight scoreboard lookups with no bypass; x0 never hazards.
    always_comb begin
        hazard_a_o = busy_q[raddr_a_i] & (raddr_a_i != 5'd0);
        hazard_b_o = busy_q[raddr_b_i] & (raddr_b_i != 5'd0);
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vectors, a transaction-level model of
// the expected register-file activity, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_writeback_unit;

    localparam int W  = 32;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          issue_ready_o;
    logic [4:0]    raddr_a;
    logic [4:0]    raddr_b;
    logic          hazard_a_o;
    logic          hazard_b_o;
    logic          alu_valid;
    logic          alu_ready_o;
    logic [4:0]    alu_rd;
    logic [W-1:0]  alu_wdata;
    logic          lsu_valid;
    logic          lsu_ready_o;
    logic [4:0]    lsu_rd;
    logic [W-1:0]  lsu_rdata;
    logic          rf_en_w_o;
    logic          rf_req_w_o;
    logic [4:0]    rf_waddr_o;
    logic [W-1:0]  rf_wdata_alu_o;
    logic [W-1:0]  rf_wdata_lsu_o;
    logic          rf_soursel_o;
    logic [CW-1:0] retire_cnt_o;
    logic [1:0]    fsm_state_o;

    writeback_unit #(.DataWidth(W), .CntWidth(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .issue_valid_i  (issue_valid),
        .issue_rd_i     (issue_rd),
        .issue_ready_o  (issue_ready_o),
        .raddr_a_i      (raddr_a),
        .raddr_b_i      (raddr_b),
        .hazard_a_o     (hazard_a_o),
        .hazard_b_o     (hazard_b_o),
        .alu_valid_i    (alu_valid),
        .alu_ready_o    (alu_ready_o),
        .alu_rd_i       (alu_rd),
        .alu_wdata_i    (alu_wdata),
        .lsu_valid_i    (lsu_valid),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_i       (lsu_rd),
        .lsu_rdata_i    (lsu_rdata),
        .rf_en_w_o      (rf_en_w_o),
        .rf_req_w_o     (rf_req_w_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_alu_o (rf_wdata_alu_o),
        .rf_wdata_lsu_o (rf_wdata_lsu_o),
        .rf_soursel_o   (rf_soursel_o),
        .retire_cnt_o   (retire_cnt_o),
        .fsm_state_o    (fsm_state_o)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One write in flight at most. Edge k is counted by cyc; a result accepted
    // at edge m_acc is in setup/strobe/hold for cycles m_acc..m_acc+2 and the
    // port is free again from m_acc+3. Busy bits and the retire count change
    // at the edge that closes the strobe cycle.
    int          cyc   = 0;
    int          m_acc = 0;
    bit          m_have = 1'b0;
    logic [4:0]  m_rd   = 5'd0;
    logic [W-1:0] m_data = '0;
    bit          m_src  = 1'b0;
    bit [31:0]   m_busy = '0;
    int unsigned m_cnt  = 0;
    int          mp;
    bit          m_idle;
    bit          m_iss_ok;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have = 1'b0;
            m_busy = '0;
            m_cnt  = 0;
            cyc    = 0;
        end else begin
            mp       = cyc - m_acc;
            m_idle   = !m_have || (mp >= 3);
            m_iss_ok = (issue_rd == 5'd0) || !m_busy[issue_rd];
            if (m_have && mp == 1 && m_rd != 5'd0) begin
                m_busy[m_rd] = 1'b0;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (issue_valid && m_iss_ok && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (m_idle && (lsu_valid || alu_valid)) begin
                m_have = 1'b1;
                m_acc  = cyc + 1;
                m_src  = lsu_valid;
                m_rd   = lsu_valid ? lsu_rd : alu_rd;
                m_data = lsu_valid ? lsu_rdata : alu_wdata;
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int cp;
    bit cfl;
    always @(negedge clk) begin
        cp  = cyc - m_acc;
        cfl = !rst && m_have && (cp <= 2);
        chk("lsu_ready", lsu_ready_o, !rst && !cfl);
        chk("alu_ready", alu_ready_o, !rst && !cfl && !lsu_valid);
        chk("req_w", rf_req_w_o, cfl && m_rd != 5'd0);
        chk("en_w", rf_en_w_o, cfl && cp == 1 && m_rd != 5'd0);
        chk("retire_cnt", retire_cnt_o, m_cnt);
        chk("hazard_a", hazard_a_o, raddr_a != 5'd0 && m_busy[raddr_a]);
        chk("hazard_b", hazard_b_o, raddr_b != 5'd0 && m_busy[raddr_b]);
        chk("issue_ready", issue_ready_o, issue_rd == 5'd0 || !m_busy[issue_rd]);
        if (cfl) begin
            chk("waddr", rf_waddr_o, m_rd);
            chk("soursel", rf_soursel_o, m_src);
            chk("wdata_alu", rf_wdata_alu_o, m_src ? '0 : m_data);
            chk("wdata_lsu", rf_wdata_lsu_o, m_src ? m_data : '0);
        end
        if (rst) begin
            chk("rst_waddr", rf_waddr_o, 0);
            chk("rst_wdata_alu", rf_wdata_alu_o, 0);
            chk("rst_wdata_lsu", rf_wdata_lsu_o, 0);
            chk("rst_soursel", rf_soursel_o, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input bit use_lsu, input logic [4:0] rd,
                            input logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        if (use_lsu) begin
            lsu_valid = 1'b1; lsu_rd = rd; lsu_rdata = d;
        end else begin
            alu_valid = 1'b1; alu_rd = rd; alu_wdata = d;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (use_lsu ? lsu_ready_o : alu_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        alu_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- global time bound ----------------
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected end before 200000ns");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    bit ok;
    initial begin
        rst = 1'b0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        raddr_a = 5'd0; raddr_b = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_wdata = '0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_rdata = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_en_w", rf_en_w_o, 0);
        chk("reset_req_w", rf_req_w_o, 0);
        chk("reset_cnt", retire_cnt_o, 0);
        chk("reset_lsu_ready", lsu_ready_o, 0);
        chk("reset_alu_ready", alu_ready_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single ALU write rd=5.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'hDEADBEEF;
        @(negedge clk); chk("t1_alu_ready", alu_ready_o, 1);
        @(posedge clk); #1 alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_setup_waddr", rf_waddr_o, 5);
        chk("t1_setup_soursel", rf_soursel_o, 0);
        chk("t1_setup_req", rf_req_w_o, 1);
        chk("t1_setup_en", rf_en_w_o, 0);
        chk("t1_setup_alu_bus", rf_wdata_alu_o, 32'hDEADBEEF);
        @(negedge clk); chk("t1_strobe_en", rf_en_w_o, 1);
        @(negedge clk); chk("t1_hold_en", rf_en_w_o, 0);
        chk("t1_cnt", retire_cnt_o, 1);
        chk("t1_hold_ready", alu_ready_o, 0);
        @(negedge clk); chk("t1_idle_ready", alu_ready_o, 1);
        chk("t1_idle_req", rf_req_w_o, 0);

        // ALU rd=3 and LSU rd=4 together: LSU first, ALU four cycles later.
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wdata = 32'h33330003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_rdata = 32'h44440004;
        @(negedge clk);
        chk("t2_lsu_ready", lsu_ready_o, 1);
        chk("t2_alu_blocked", alu_ready_o, 0);
        @(posedge clk); #1 lsu_valid = 1'b0;
        @(negedge clk);
        chk("t2_lsu_waddr", rf_waddr_o, 4);
        chk("t2_lsu_soursel", rf_soursel_o, 1);
        chk("t2_lsu_bus", rf_wdata_lsu_o, 32'h44440004);
        chk("t2_alu_bus_zero", rf_wdata_alu_o, 0);
        repeat (3) @(negedge clk);
        chk("t2_alu_ready_late", alu_ready_o, 1);
        @(posedge clk); #1 alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_alu_waddr", rf_waddr_o, 3);
        chk("t2_alu_soursel", rf_soursel_o, 0);
        chk("t2_alu_bus", rf_wdata_alu_o, 32'h33330003);
        repeat (2) @(negedge clk);
        chk("t2_cnt", retire_cnt_o, 3);

        // Scoreboard: issue rd=7, WAW stall, cleared by writeback.
        @(posedge clk); #1 issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk); chk("t3_issue_ready", issue_ready_o, 1);
        @(posedge clk); #1 issue_valid = 1'b0; raddr_a = 5'd7;
        @(negedge clk); chk("t3_hazard_set", hazard_a_o, 1);
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_rd = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wdata = 32'h00000077;
        @(negedge clk); chk("t3_waw_stall", issue_ready_o, 0);
        @(posedge clk); #1 alu_valid = 1'b0;
        @(negedge clk); chk("t3_setup_hazard", hazard_a_o, 1);
        @(negedge clk); chk("t3_strobe_hazard", hazard_a_o, 1);
        chk("t3_strobe_stall", issue_ready_o, 0);
        @(negedge clk);
        chk("t3_hold_hazard", hazard_a_o, 0);
        chk("t3_hold_issue_ready", issue_ready_o, 1);
        chk("t3_cnt", retire_cnt_o, 4);
        @(posedge clk); #1 issue_valid = 1'b0;
        @(negedge clk); chk("t3_reissued", hazard_a_o, 1);

        // x0 result: sequenced but never written, count unchanged.
        @(posedge clk); #1;
        raddr_a = 5'd0; raddr_b = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'h12345678;
        @(negedge clk);
        chk("t4_hazard_x0", hazard_a_o, 0);
        chk("t4_hazard_b7", hazard_b_o, 1);
        chk("t4_issue_x0", issue_ready_o, 1);
        chk("t4_alu_ready", alu_ready_o, 1);
        @(posedge clk); #1 issue_valid = 1'b0; alu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_req_low", rf_req_w_o, 0);
            chk("t4_en_low", rf_en_w_o, 0);
        end
        chk("t4_cnt", retire_cnt_o, 4);
        @(negedge clk); chk("t4_back_idle", alu_ready_o, 1);

        // Reset during STROBE drops en_w without a clock edge.
        @(posedge clk); #1 alu_valid = 1'b1; alu_rd = 5'd9; alu_wdata = 32'h00000099;
        @(negedge clk);
        @(posedge clk); #1 alu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("t5_strobe_en", rf_en_w_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_en", rf_en_w_o, 0);
        chk("t5_async_req", rf_req_w_o, 0);
        chk("t5_busy_clear", hazard_b_o, 0);
        chk("t5_cnt", retire_cnt_o, 0);
        chk("t5_ready_low", lsu_ready_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        do_write(1'b1, 5'd2, 32'h0000ABCD, ok);
        chk("t5_post_reset_accept", ok, 1);
        chk("t5_post_cnt", retire_cnt_o, 1);

        // Counter wrap at CntWidth=4.
        for (int i = 0; i < 14; i++) begin
            do_write(i[0], 5'(1 + i), 32'h1000 + i, ok);
            chk("t6_accept", ok, 1);
        end
        chk("t6_cnt_max", retire_cnt_o, 15);
        do_write(1'b0, 5'd20, 32'hCAFE0000, ok);
        chk("t6_accept_last", ok, 1);
        chk("t6_cnt_wrap", retire_cnt_o, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
